// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction-fetch front end.
package fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DROP,
      HALT
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small FIFO of fetched {pc, instr} entries.
// While empty, rd_data holds the last entry that was presented.
// flush dominates push.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  fetch_entry_t                 wr_data,
   output fetch_entry_t                 rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t   mem [DEPTH];
   fetch_entry_t   hold;
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic           do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign rd_data = empty ? hold : mem[rd_ptr];

   // Storage, pointers and occupancy; a flush empties the FIFO in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Remember the presented head so outputs stay put once the FIFO drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      hold <= '0;
      else if (!empty) hold <= mem[rd_ptr];
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch front end of the RV32 core.
// One request outstanding at most; responses are registered into fetch_buffer.
// Build macro FETCH_MISALIGN_CHECK_EN: misaligned branch targets trap and halt
// fetch instead of redirecting (otherwise target[1:0] is forced to zero).
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        stall,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        misalign_trap
`endif
);
   localparam int CW = $clog2(BUF_DEPTH + 1);

   fetch_state_t  state, state_nx;
   logic [31:0]   pc, pc_nx, req_pc, tgt;
   logic          req_held, req_fire, redirect, live_out;
   logic          push_nx, flush, buf_push, buf_pop, buf_full, buf_empty;
   logic [CW-1:0] buf_count;
   fetch_entry_t  wr_entry, rd_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign, trap_nx, halt_pend;
   assign misalign = branch_taken && (branch_target[1:0] != 2'b00);
   assign redirect = branch_taken && !misalign;
   assign tgt      = branch_target;
`else
   assign redirect = branch_taken;
   assign tgt      = branch_target & ~32'h3;
`endif

   // In REQ nothing is outstanding, so buffer occupancy alone bounds issue.
   // A raised request stays up until accepted; stall only blocks new ones.
   assign imem_req_valid = (state == REQ) &&
                           (req_held || (!stall && (int'(buf_count) < BUF_DEPTH)));
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign imem_req_addr  = pc;

   assign buf_pop     = instr_valid && instr_ready;
   assign buf_push    = push_nx && (!buf_full || buf_pop);
   assign wr_entry    = '{pc: req_pc, instr: imem_rsp_data};
   assign instr_valid = !buf_empty;
   assign instr       = rd_entry.instr;
   assign instr_pc    = rd_entry.pc;

   // Next-state, PC update and buffer control; redirect overrides everything.
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      push_nx  = 1'b0;
      flush    = 1'b0;
      // A response still owed to us after this cycle (one landing now is consumed).
      live_out = req_fire || (((state == WAIT) || (state == DROP)) && !imem_rsp_valid);
`ifdef FETCH_MISALIGN_CHECK_EN
      trap_nx  = 1'b0;
      if ((state == HALT) && halt_pend && !imem_rsp_valid) live_out = 1'b1;
`endif
      case (state)
         IDLE: state_nx = REQ;
         REQ: begin
            if (req_fire) begin
               pc_nx    = pc + 32'(INSTR_BYTES);
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               push_nx  = 1'b1;
               state_nx = REQ;
            end
         end
         DROP: if (imem_rsp_valid) state_nx = REQ;
         default: ;
      endcase
      if (redirect) begin
         pc_nx    = tgt;
         push_nx  = 1'b0;
         flush    = 1'b1;
         state_nx = live_out ? DROP : REQ;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      else if (misalign) begin
         push_nx  = 1'b0;
         flush    = 1'b1;
         trap_nx  = 1'b1;
         state_nx = HALT;
      end
`endif
   end

   // State, PC, PC of the outstanding request and request-hold tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         req_pc   <= RESET_PC;
         req_held <= 1'b0;
      end else begin
         state    <= state_nx;
         pc       <= pc_nx;
         if (req_fire) req_pc <= pc;
         req_held <= imem_req_valid && !imem_req_ready && !branch_taken;
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   // Trap pulse, and whether a response is still owed while halted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_trap <= 1'b0;
         halt_pend     <= 1'b0;
      end else begin
         misalign_trap <= trap_nx;
         if (redirect)            halt_pend <= 1'b0;
         else if (misalign)       halt_pend <= live_out;
         else if (imem_rsp_valid) halt_pend <= 1'b0;
      end
   end
`endif

   fetch_buffer #(
      .DEPTH(BUF_DEPTH)
   ) u_buf (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (buf_push),
      .pop    (buf_pop),
      .flush  (flush),
      .wr_data(wr_entry),
      .rd_data(rd_entry),
      .count  (buf_count),
      .full   (buf_full),
      .empty  (buf_empty)
   );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench with a fixed-latency memory model and an
// in-order scoreboard of expected instruction PCs.
module tb_pc_fetch_unit;
   logic        clk;
   logic        rst_n;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        stall;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misalign_trap;
`endif

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];    // PCs decode must see, in order
   logic [31:0] acc_q[$];    // addresses memory accepted
   logic [31:0] exp_acc[$];  // addresses memory should have accepted

   int          lat = 1;
   logic        pend = 1'b0;
   int          cnt = 0;
   logic [31:0] paddr = '0;

   pc_fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .stall         (stall),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr (imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .instr_pc      (instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .misalign_trap (misalign_trap)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ 32'hC0DE_5A00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_acc(input string tag);
      chk({tag, "_count"}, 32'(acc_q.size()), 32'(exp_acc.size()));
      for (int i = 0; i < exp_acc.size(); i++)
         chk(tag, (i < acc_q.size()) ? acc_q[i] : 32'hxxxx_xxxx, exp_acc[i]);
      acc_q.delete();
      exp_acc.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Memory model: observes the request at mid-cycle, answers lat cycles after acceptance.
   always @(negedge clk) begin
      imem_rsp_valid = 1'b0;
      if (!rst_n) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_f(paddr);
               pend           = 1'b0;
            end
         end
         if (imem_req_valid && imem_req_ready) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = imem_req_addr;
            acc_q.push_back(imem_req_addr);
         end
      end
   end

   // Scoreboard: each instruction handed to decode must be the next expected one.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready) begin
         n_chk++;
         assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL extra_instr: observed pc %h expected none", instr_pc);
         end
         if (exp_q.size() != 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e);
            chk("instr_data", instr, mem_f(e));
         end
      end
   end

   initial begin
      rst_n          = 1'b0;
      branch_taken   = 1'b0;
      branch_target  = '0;
      stall          = 1'b0;
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;

      // Reset state
      tick(3);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_addr", imem_req_addr, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("rst_trap", 32'(misalign_trap), 32'd0);
`endif

      // 1: sequential fetch after reset release
      rst_n = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
      exp_acc.push_back(32'h0); exp_acc.push_back(32'h4); exp_acc.push_back(32'h8);
      tick(1);
      chk("t1_first_valid", 32'(imem_req_valid), 32'd1);
      chk("t1_first_addr", imem_req_addr, 32'h0);
      tick(1);
      chk("t1_ivalid_early", 32'(instr_valid), 32'd0);
      tick(1);
      chk("t1_ivalid", 32'(instr_valid), 32'd1);
      chk("t1_ipc", instr_pc, 32'h0);
      tick(3);
      stall = 1'b1;
      tick(4);
      chk_acc("t1_addr");

      // 2: decode back-pressure fills the buffer, then resumes
      instr_ready = 1'b0;
      stall       = 1'b0;
      exp_q.push_back(32'hC);  exp_q.push_back(32'h10);
      exp_q.push_back(32'h14); exp_q.push_back(32'h18);
      exp_acc.push_back(32'hC);  exp_acc.push_back(32'h10);
      exp_acc.push_back(32'h14); exp_acc.push_back(32'h18);
      tick(4);
      chk("t2_full_no_req", 32'(imem_req_valid), 32'd0);
      chk("t2_head_valid", 32'(instr_valid), 32'd1);
      chk("t2_head_pc", instr_pc, 32'hC);
      tick(2);
      chk("t2_full_no_req2", 32'(imem_req_valid), 32'd0);
      instr_ready = 1'b1;
      tick(4);
      stall = 1'b1;
      tick(4);
      chk_acc("t2_addr");

      // 3: redirect while a slow response is outstanding
      instr_ready = 1'b0;
      stall       = 1'b0;
      lat         = 3;
      exp_acc.push_back(32'h1C); exp_acc.push_back(32'h20); exp_acc.push_back(32'h100);
      tick(5);
      chk("t3_buffered", instr_pc, 32'h1C);
      branch_taken  = 1'b1;
      branch_target = 32'h100;
      tick(1);
      branch_taken = 1'b0;
      chk("t3_flushed", 32'(instr_valid), 32'd0);
      chk("t3_drop_no_req", 32'(imem_req_valid), 32'd0);
      chk("t3_addr_tgt", imem_req_addr, 32'h100);
      tick(2);
      chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
      chk("t3_req_addr", imem_req_addr, 32'h100);
      lat         = 1;
      instr_ready = 1'b1;
      exp_q.push_back(32'h100);
      tick(1);
      stall = 1'b1;
      tick(1);
      chk("t3_ipc", instr_pc, 32'h100);
      tick(3);
      chk_acc("t3_addr");

      // 4: PC wraps modulo 2^32; stalled redirect keeps request low
      branch_taken  = 1'b1;
      branch_target = 32'hFFFF_FFFC;
      tick(1);
      branch_taken = 1'b0;
      chk("t4_stall_no_req", 32'(imem_req_valid), 32'd0);
      chk("t4_addr_tgt", imem_req_addr, 32'hFFFF_FFFC);
      stall = 1'b0;
      exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
      exp_acc.push_back(32'hFFFF_FFFC); exp_acc.push_back(32'h0);
      tick(1);
      chk("t4_wrap_addr", imem_req_addr, 32'h0);
      tick(2);
      stall = 1'b1;
      tick(4);
      chk_acc("t4_addr");

      // 5: redirect, response and stall in the same cycle
      stall = 1'b0;
      exp_acc.push_back(32'h4); exp_acc.push_back(32'h300);
      tick(1);
      branch_taken  = 1'b1;
      branch_target = 32'h300;
      stall         = 1'b1;
      tick(1);
      branch_taken = 1'b0;
      chk("t5_no_req", 32'(imem_req_valid), 32'd0);
      chk("t5_addr_tgt", imem_req_addr, 32'h300);
      chk("t5_rsp_not_pushed", 32'(instr_valid), 32'd0);
      tick(2);
      chk("t5_still_stalled", 32'(imem_req_valid), 32'd0);
      stall = 1'b0;
      #1;
      chk("t5_req_resume", 32'(imem_req_valid), 32'd1);
      exp_q.push_back(32'h300);
      tick(1);
      stall = 1'b1;
      tick(4);
      chk_acc("t5_addr");

`ifdef FETCH_MISALIGN_CHECK_EN
      // 6: misaligned target traps and halts; aligned redirect resumes
      stall = 1'b0;
      lat   = 3;
      exp_acc.push_back(32'h304); exp_acc.push_back(32'h200);
      tick(1);
      branch_taken  = 1'b1;
      branch_target = 32'h102;
      tick(1);
      branch_taken = 1'b0;
      chk("t6_trap", 32'(misalign_trap), 32'd1);
      chk("t6_halt_no_req", 32'(imem_req_valid), 32'd0);
      tick(1);
      chk("t6_trap_pulse", 32'(misalign_trap), 32'd0);
      tick(3);
      chk("t6_halt_no_req2", 32'(imem_req_valid), 32'd0);
      chk("t6_rsp_dropped", 32'(instr_valid), 32'd0);
      branch_taken  = 1'b1;
      branch_target = 32'h200;
      lat           = 1;
      tick(1);
      branch_taken = 1'b0;
      chk("t6_resume_addr", imem_req_addr, 32'h200);
      chk("t6_resume_valid", 32'(imem_req_valid), 32'd1);
      exp_q.push_back(32'h200);
      tick(1);
      stall = 1'b1;
      tick(4);
      chk_acc("t6_addr");
`endif

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
